// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for one shared FIFO write port
module fifo_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int DATA  = 8,
    parameter int BURST = 4
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DATA-1:0] req_data,
    input  logic                 full,
    output logic [NREQ-1:0]      gnt,
    output logic                 w_en,
    output logic [DATA-1:0]      wdata,
    output logic [1:0]           owner,
    output logic                 busy
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_owner_q, last_owner_d;
    logic [3:0] count_q, count_d;
    logic [1:0] winner;
    logic       found;

    // Search starts one past the last releaser; the 2-bit sum wraps modulo NREQ.
    always_comb begin
        winner = last_owner_q;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[last_owner_q + 2'(k)]) begin
                winner = last_owner_q + 2'(k);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        count_d      = count_q;
        w_en         = (state_q == HOLD) && req[owner_q] && !full;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    count_d = 4'd0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (w_en) begin
                    count_d = count_q + 4'd1;
                end
                // A full stall keeps the tenure; only a last beat or a dropped request ends it.
                if ((w_en && count_q == LAST_BEAT) || !req[owner_q]) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            last_owner_q <= 2'(NREQ - 1);
            count_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
        end
    end

    assign gnt   = w_en ? (NREQ'(1) << owner_q) : '0;
    assign wdata = req_data[int'(owner_q)*DATA +: DATA];
    assign owner = owner_q;
    assign busy  = (state_q == HOLD);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
    localparam int NREQ  = 4;
    localparam int DATA  = 8;
    localparam int BURST = 4;

    logic             wclk = 1'b0;
    logic             wrst = 1'b1;
    logic [NREQ-1:0]  req  = '0;
    logic [NREQ*DATA-1:0] req_data;
    logic             full = 1'b0;
    logic [NREQ-1:0]  gnt;
    logic             w_en;
    logic [DATA-1:0]  wdata;
    logic [1:0]       owner;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] dval [NREQ];
    logic [7:0] dstep[NREQ];

    // Requester-level reference: tenure holder, last releaser, beats written so far.
    bit         m_busy;
    int         m_owner;
    int         m_last;
    int         m_beats;
    logic       exp_w_en;
    logic [3:0] exp_gnt;
    logic [7:0] exp_wdata;
    logic [7:0] obs_data[$];
    logic       inv_bad;

    fifo_write_arbiter #(.NREQ(NREQ), .DATA(DATA), .BURST(BURST)) dut (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .full(full),
        .gnt(gnt), .w_en(w_en), .wdata(wdata), .owner(owner), .busy(busy)
    );

    always #5 wclk = ~wclk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DATA +: DATA] = dval[i];
    end

    always @(negedge wclk) begin
        checks++;
        inv_bad = (w_en && full) || !$onehot0(gnt);
        for (int i = 0; i < NREQ; i++)
            if (gnt[i] && (!w_en || wdata !== req_data[i*DATA +: DATA])) inv_bad = 1'b1;
        if (inv_bad) begin
            errors++;
            $display("FAIL invariant t=%0t: w_en=%b full=%b gnt=%b wdata=%h req_data=%h", $time, w_en, full, gnt, wdata, req_data);
        end
    end

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_beats = 0;
    endtask

    function automatic logic [15:0] obs_vec();
        return {busy, busy ? owner : 2'b00, w_en, gnt, busy ? wdata : 8'h00};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_busy, m_busy ? 2'(m_owner) : 2'b00, exp_w_en, exp_gnt, m_busy ? exp_wdata : 8'h00};
    endfunction

    task automatic sample();
        @(negedge wclk);
        exp_w_en  = m_busy && req[m_owner] && !full;
        exp_gnt   = exp_w_en ? (4'b0001 << m_owner) : 4'b0000;
        exp_wdata = dval[m_owner];
        if (w_en) obs_data.push_back(wdata);
    endtask

    task automatic advance();
        @(posedge wclk);
        for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) dval[i] = dval[i] + dstep[i];
        if (!wrst) begin
            model_reset();
        end else if (!m_busy) begin
            if (req != 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (req[(m_last + k) % NREQ]) begin
                        m_owner = (m_last + k) % NREQ;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_beats = 0;
            end
        end else begin
            if (exp_w_en) m_beats++;
            if ((exp_w_en && m_beats == BURST) || !req[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        req  = '0;
        full = 1'b0;
        wrst = 1'b0;
        model_reset();
        exp_gnt = '0;
        @(posedge wclk);
        #1;
        wrst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            dval[i]  = 8'($urandom);
            dstep[i] = 8'd1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin dval[i] = 8'(i); dstep[i] = 8'd1; end
        model_reset();
        exp_gnt = '0;
        req = 4'b1111;
        #1;
        wrst = 1'b0;
        #1;
        checks++;
        if ({busy, owner, w_en, gnt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: got busy/owner/w_en/gnt=%h want 00", {busy, owner, w_en, gnt});
        end
        @(posedge wclk);
        #1;
        wrst = 1'b1;
        repeat (6) begin
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_first_arb t=%0t: got %h want %h", $time, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_single();
        logic [7:0] want;
        do_reset();
        dval[1]  = 8'h11;
        dstep[1] = 8'h11;
        req = 4'b0010;
        obs_data.delete();
        repeat (10) begin
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single t=%0t: got %h want %h", $time, obs_vec(), exp_vec());
            end
            advance();
        end
        checks++;
        if (obs_data.size() != 8) begin
            errors++;
            $display("FAIL single_beats: got %0d beats want 8", obs_data.size());
        end
        for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
            want = 8'h11 * 8'(i + 1);
            checks++;
            if (obs_data[i] !== want) begin
                errors++;
                $display("FAIL single_data[%0d]: got %h want %h", i, obs_data[i], want);
            end
        end
    endtask

    task automatic test_all_requesting();
        int   owners[$];
        logic prev_busy;
        do_reset();
        req = 4'b1111;
        prev_busy = 1'b0;
        repeat (26) begin
            sample();
            if (busy && !prev_busy) owners.push_back(int'(owner));
            prev_busy = busy;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL all_req t=%0t: got %h want %h", $time, obs_vec(), exp_vec());
            end
            advance();
        end
        checks++;
        if (owners.size() < 5) begin
            errors++;
            $display("FAIL all_req_tenures: got %0d tenures want 5", owners.size());
        end
        for (int i = 0; i < 5 && i < owners.size(); i++) begin
            checks++;
            if (owners[i] != i % NREQ) begin
                errors++;
                $display("FAIL all_req_order[%0d]: got %0d want %0d", i, owners[i], i % NREQ);
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 15; c++) begin
            full = (c >= 3 && c < 8);
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_stall t=%0t: got %h want %h", $time, obs_vec(), exp_vec());
            end
            if (full) begin
                checks++;
                if (!(busy && owner == 2'd2 && !w_en && gnt == 4'b0)) begin
                    errors++;
                    $display("FAIL full_hold c=%0d: got busy=%b owner=%0d w_en=%b gnt=%b want 1/2/0/0", c, busy, owner, w_en, gnt);
                end
            end
            if (c == 9) begin
                checks++;
                if (!(busy && w_en)) begin
                    errors++;
                    $display("FAIL full_resume: got busy=%b w_en=%b want 1/1", busy, w_en);
                end
            end
            if (c == 10) begin
                checks++;
                if (busy) begin
                    errors++;
                    $display("FAIL full_release: got busy=%b want 0", busy);
                end
                req = 4'b0000;
            end
            advance();
        end
    endtask

    task automatic test_early_drop();
        int next_owner;
        do_reset();
        req = 4'b1001;
        next_owner = -1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) req = 4'b1000;
            sample();
            if (c >= 3 && busy && next_owner < 0) next_owner = int'(owner);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL early_drop t=%0t: got %h want %h", $time, obs_vec(), exp_vec());
            end
            advance();
        end
        checks++;
        if (next_owner != 3) begin
            errors++;
            $display("FAIL early_drop_next: got owner %0d want 3", next_owner);
        end
    endtask

    task automatic test_reset_mid();
        int first_owner;
        do_reset();
        req = 4'b1000;
        repeat (3) begin
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_pre t=%0t: got %h want %h", $time, obs_vec(), exp_vec());
            end
            advance();
        end
        wrst = 1'b0;
        #1;
        checks++;
        if ({busy, owner, w_en, gnt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: got busy/owner/w_en/gnt=%h want 00", {busy, owner, w_en, gnt});
        end
        model_reset();
        req = 4'b1001;
        sample();
        advance();
        wrst = 1'b1;
        first_owner = -1;
        repeat (4) begin
            sample();
            if (busy && first_owner < 0) first_owner = int'(owner);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_post t=%0t: got %h want %h", $time, obs_vec(), exp_vec());
            end
            advance();
        end
        checks++;
        if (first_owner != 0) begin
            errors++;
            $display("FAIL reset_mid_owner: got %0d want 0", first_owner);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < NREQ; i++) dstep[i] = 8'($urandom_range(1, 255));
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, NREQ-1)] ^= 1'b1;
            full = ($urandom_range(0, 3) == 0);
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random t=%0t req=%b full=%b: got %h want %h", $time, req, full, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_full_stall();
        test_early_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters sharing one asynchronous FIFO write port (fixed at 4; 2-bit owner).
REQ-002 Parameter DATA, default 8, data width; SHALL match the FIFO DATA parameter.
REQ-003 Parameter BURST, default 4, maximum beats per grant tenure (range 1..15).
REQ-004 wclk  input  1  write-domain clock, all state on posedge.
REQ-005 wrst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester write request; data valid while high.
REQ-007 req_data  input  NREQ*DATA  requester data; slice i = bits [i*DATA +: DATA].
REQ-008 full  input  1  FIFO full flag, wclk domain.
REQ-009 gnt  output  NREQ  one-hot beat acknowledge; requester i advances its data when gnt[i]=1.
REQ-010 w_en  output  1  FIFO write enable.
REQ-011 wdata  output  DATA  FIFO write data.
REQ-012 owner  output  2  index of current tenure holder.
REQ-013 busy  output  1  high while in HOLD state.

Function
REQ-014 FSM states SHALL be IDLE and HOLD only.
REQ-015 IDLE: if req != 0, SHALL select winner by round-robin, latch owner, clear beat count, enter HOLD on the next edge; if req == 0, remain IDLE.
REQ-016 Round-robin search SHALL start at (last_owner+1) mod NREQ, ascending with wrap; last_owner updates on each release.
REQ-017 Arbitration latency: req rising in IDLE at edge n -> owner valid after edge n -> first possible w_en in the following cycle (1-cycle bubble).
REQ-018 HOLD: w_en SHALL be combinational = req[owner] AND NOT full.
REQ-019 wdata SHALL equal req_data slice [owner] whenever busy=1, regardless of w_en.
REQ-020 gnt[i] SHALL equal w_en AND (owner==i); gnt SHALL be all-zero in IDLE.
REQ-021 Each edge with w_en=1 SHALL increment the 4-bit beat count by 1.
REQ-022 Release (HOLD->IDLE) SHALL occur on the edge where either (w_en=1 and count==BURST-1) or req[owner]=0.
REQ-023 full=1 SHALL stall without releasing: no w_en, no gnt, count frozen, tenure retained indefinitely.
REQ-024 Non-owner req changes during HOLD SHALL have no effect until the next IDLE arbitration.
REQ-025 w_en SHALL never be 1 while full=1; at most one gnt bit high per cycle.
REQ-026 BURST=1: every tenure SHALL be exactly one beat.

Reset
REQ-027 wrst low SHALL immediately force: state IDLE, owner=0, last_owner=NREQ-1 (first search starts at 0), count=0, busy=0, gnt=0, w_en=0.
REQ-028 Reset asserted mid-tenure SHALL abort the tenure with no further w_en; beats already written are not retracted.
REQ-029 After wrst release, first arbitration SHALL occur on the first wclk edge with req != 0.

Verification
REQ-030 Single requester: req=4'b0010, data 0x11,0x22,... advanced on gnt, full=0, BURST=4 -> owner=1; w_en on 4 consecutive cycles, wdata 0x11..0x44; release; 1 IDLE cycle; new tenure of 4.
REQ-031 All requesting: req=4'b1111 continuously after reset -> owners 0,1,2,3,0 in order, each exactly 4 beats, 1 bubble between tenures.
REQ-032 Full stall: owner 2 after 2 beats, full=1 for 5 cycles -> w_en=0, gnt=0, owner stays 2, busy=1; full=0 -> remaining 2 beats, then release.
REQ-033 Early drop: owner 0, req[0] falls after 1 beat while req[3]=1 -> release on that edge, next owner 3 (not 1 or 2 unless requesting).
REQ-034 Reset mid-tenure: owner 3 at beat 2, wrst low -> same-cycle w_en=0, gnt=0, busy=0, owner=0; after release with req=4'b1001 -> first owner 0.
REQ-035 Checker across all scenarios: never w_en with full=1; gnt one-hot or zero; gnt[i] implies w_en and wdata == req_data slice i.
